// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pkg
//  Description : Shared servo timing constants, arm positions and data types.
//  Revision    : 1.0
// ============================================================================
package servo_pkg;

   localparam int unsigned FRAME_LEN     = 2000000;
   localparam int unsigned MIN_PULSE     = 50000;
   localparam int unsigned MAX_POS       = 200000;

   localparam int unsigned CLAW_OPEN     = 1;
   localparam int unsigned CLAW_CLOSE    = 199218;
   localparam int unsigned UPPER_PICKUP  = 31248;
   localparam int unsigned UPPER_DROPOFF = 191394;
   localparam int unsigned LOWER_PICKUP  = 183400;
   localparam int unsigned LOWER_DROPOFF = 113274;

   typedef logic [19:0] pos_t;
   typedef logic [21:0] width_t;
   typedef logic [27:0] count_t;

endpackage
`default_nettype wire

// File: rtl/servo.sv
`default_nettype none
// ============================================================================
//  Module      : servo
//  Description : Slew-limited servo position with glitch-free per-frame PWM.
//  Revision    : 1.0
// ============================================================================
module servo
   import servo_pkg::*;
#(
   parameter int unsigned MIN_PULSE = servo_pkg::MIN_PULSE,
   parameter int unsigned MAX_POS   = servo_pkg::MAX_POS,
   parameter int unsigned STEP      = 64
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         SLK,
   input  logic [27:0]  COUNT,
   input  logic [19:0]  DESIRED,
   output logic         PWM,
   output logic         FLAG
);

   pos_t   cur;
   pos_t   target;
   pos_t   diff;
   pos_t   next_cur;
   width_t width;
   logic   slk_d;
   logic   up;
   logic   tick;

   assign tick = SLK & ~slk_d;

   always_comb begin
      target   = (DESIRED > pos_t'(MAX_POS)) ? pos_t'(MAX_POS) : DESIRED;
      up       = (target >= cur);
      diff     = up ? (target - cur) : (cur - target);
      next_cur = cur;
      // Within one step snap to target, so the move never overshoots or wraps.
      if (diff <= pos_t'(STEP)) begin
         next_cur = target;
      end else if (up) begin
         next_cur = cur + pos_t'(STEP);
      end else begin
         next_cur = cur - pos_t'(STEP);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cur   <= '0;
         width <= '0;
         slk_d <= 1'b0;
         PWM   <= 1'b0;
         FLAG  <= 1'b0;
      end else begin
         slk_d <= SLK;
         if (tick) begin
            cur <= next_cur;
         end
         // Width is latched once per frame from the pre-tick position.
         if (COUNT == '0) begin
            width <= width_t'(MIN_PULSE) + width_t'(cur);
         end
         PWM  <= (COUNT < count_t'(width));
         FLAG <= (cur == target);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_servo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo
//  Description : Scoreboard bench for servo with a behavioural reference model.
//  Revision    : 1.0
// ============================================================================
module tb_servo;

   localparam int MINP  = 40;
   localparam int MAXP  = 200;
   localparam int STP   = 8;
   localparam int FRAME = 300;

   typedef struct {
      bit pwm;
      bit flag;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        SLK;
   logic [27:0] COUNT;
   logic [19:0] DESIRED;
   logic        PWM;
   logic        FLAG;

   int   checks   = 0;
   int   failures = 0;
   bit   done     = 0;
   exp_t q[$];

   int m_cur   = 0;
   int m_width = 0;
   bit m_slkd  = 0;

   int cnt      = 0;
   bit rand_slk = 0;

   servo #(
      .MIN_PULSE (MINP),
      .MAX_POS   (MAXP),
      .STEP      (STP)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .SLK     (SLK),
      .COUNT   (COUNT),
      .DESIRED (DESIRED),
      .PWM     (PWM),
      .FLAG    (FLAG)
   );

   always #5 CLK = ~CLK;

   // Reference model: evaluates the expected outputs of this edge, then advances.
   always @(posedge CLK) begin
      exp_t e;
      int   tgt;
      int   d;
      tgt = (int'(DESIRED) > MAXP) ? MAXP : int'(DESIRED);
      if (RST) begin
         e.pwm  = 1'b0;
         e.flag = 1'b0;
      end else begin
         e.pwm  = (int'(COUNT) < m_width);
         e.flag = (m_cur == tgt);
      end
      q.push_back(e);
      if (RST) begin
         m_cur   = 0;
         m_width = 0;
         m_slkd  = 0;
      end else begin
         if (COUNT == 0) m_width = MINP + m_cur;
         if (SLK && !m_slkd) begin
            d = tgt - m_cur;
            if (d > STP)       m_cur = m_cur + STP;
            else if (d < -STP) m_cur = m_cur - STP;
            else               m_cur = tgt;
         end
         m_slkd = SLK;
      end
   end

   // Monitor: the DUT presents one result per clock edge.
   always @(posedge CLK) begin
      exp_t e;
      #1;
      if (!done) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty at %0t: actual=no entry required=entry", $time);
         end else begin
            e = q.pop_front();
            checks++;
            if (PWM !== e.pwm) begin
               failures++;
               $display("FAIL pwm at %0t: actual=%b required=%b count=%0d", $time, PWM, e.pwm, COUNT);
            end
            checks++;
            if (FLAG !== e.flag) begin
               failures++;
               $display("FAIL flag at %0t: actual=%b required=%b desired=%0d", $time, FLAG, e.flag, DESIRED);
            end
         end
      end
   end

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         cnt   = (cnt >= FRAME - 1) ? 0 : cnt + 1;
         COUNT = 28'(cnt);
         SLK   = rand_slk ? 1'($urandom_range(0, 1)) : cnt[2];
      end
   endtask

   task automatic run_to(input int c);
      for (int i = 0; i < 4 * FRAME && cnt != c; i++) run(1);
   endtask

   initial begin
      RST     = 1'b1;
      SLK     = 1'b0;
      COUNT   = '0;
      DESIRED = '0;
      run(3);
      RST = 1'b0;
      run(2 * FRAME);

      // Slew up to an exact multiple of the step
      DESIRED = 20'd40;
      run(3 * FRAME);

      // Small move after reset: one full step then snap
      RST = 1'b1;
      run(2);
      RST     = 1'b0;
      DESIRED = 20'd12;
      run(2 * FRAME);

      // Above range clamps to the maximum
      DESIRED = 20'd250;
      run(3 * FRAME);

      // Near-max then retarget mid-frame to 1
      DESIRED = 20'd199;
      run(2 * FRAME);
      run_to(100);
      DESIRED = 20'd1;
      run(3 * FRAME);

      // Reset in the middle of a pulse
      DESIRED = 20'd100;
      run(3 * FRAME);
      run_to(50);
      RST = 1'b1;
      run(1);
      RST = 1'b0;
      run(2 * FRAME);

      // Randomized traffic: retargets, counter jumps, random strobe and resets
      rand_slk = 1;
      for (int i = 0; i < 4000; i++) begin
         run(1);
         if ($urandom_range(0, 49) == 0) DESIRED = 20'($urandom_range(0, 260));
         if ($urandom_range(0, 199) == 0) cnt = $urandom_range(0, 5000);
         if ($urandom_range(0, 499) == 0) RST = 1'b1;
         else RST = 1'b0;
      end
      RST = 1'b0;
      run(4);

      @(negedge CLK);
      done = 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
